// File: rtl/sync_ram_clr.sv
// -----------------------------------------------------------------------------
// sync_ram_clr
//   Single-port synchronous RAM with a built-in clear engine. After reset, and
//   whenever `clear` is pulsed, the array is swept to zero one word per cycle.
//   Accesses presented while the sweep runs are ignored.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; restarts the clear sweep
//   cs         chip select; an access is taken only when high (and idle)
//   wr         1 = write, 0 = read (qualified by cs)
//   addr       word address; addresses >= MEMORY_SIZE are out of range
//   data_in    write data
//   clear      single-cycle request to zero the whole array
//   data_out   registered read data; held between reads
//   valid      one-cycle strobe marking a new read result on data_out
//   busy       high while the clear sweep runs
//   state_dbg  current FSM state (1 = CLEAR, 0 = IDLE)
//
// Handshake: there is no ready/backpressure. A read issued at edge N is
// answered by valid=1 with data_out during the cycle after edge N; valid is
// a strobe, never held. Writes return nothing.
// -----------------------------------------------------------------------------
module sync_ram_clr #(
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 8,
  parameter int MEMORY_SIZE = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 wr,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 clear,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 state_dbg
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Last pointer value of the sweep and the exclusive upper address bound.
  // The bound carries one extra bit so MEMORY_SIZE == 2**ADDR_SIZE still fits.
  localparam logic [ADDR_SIZE-1:0] LAST_PTR  = ADDR_SIZE'(MEMORY_SIZE - 1);
  localparam logic [ADDR_SIZE:0]   MEM_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);

  logic [WORD_SIZE-1:0] mem [0:MEMORY_SIZE-1];

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;

  logic                 in_range;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = '0;
    in_range   = ({1'b0, addr} < MEM_LIMIT);

    case (state_q)
      ST_CLEAR: begin
        // Zero the current word every cycle; a fresh clear request simply
        // rewinds the pointer so the sweep covers the whole array again.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        if (clear) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // clear wins over an access presented in the same cycle.
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (cs) begin
          if (wr) begin
            mem_we    = in_range;
            mem_waddr = addr;
            mem_wdata = data_in;
          end else begin
            valid_d    = 1'b1;
            data_out_d = in_range ? mem[addr] : '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  // The array itself has no reset; the post-reset sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign busy      = (state_q == ST_CLEAR);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sync_ram_clr.sv
// -----------------------------------------------------------------------------
// tb_sync_ram_clr
//   Bench for sync_ram_clr. Instance u_dut uses the default geometry
//   (1024 x 8); u_dut2 uses MEMORY_SIZE=600 to exercise out-of-range
//   addresses and a short sweep. Inputs change 1 time unit after the rising
//   edge and outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_sync_ram_clr;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     = 1'b0;
  logic       cs      = 1'b0;
  logic       wr      = 1'b0;
  logic       clear   = 1'b0;
  logic [9:0] addr    = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       valid, busy, state_dbg;

  logic       cs2      = 1'b0;
  logic       wr2      = 1'b0;
  logic       clear2   = 1'b0;
  logic [9:0] addr2    = '0;
  logic [7:0] data_in2 = '0;
  logic [7:0] data_out2;
  logic       valid2, busy2, state_dbg2;

  sync_ram_clr u_dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .addr(addr), .data_in(data_in),
    .clear(clear), .data_out(data_out), .valid(valid), .busy(busy),
    .state_dbg(state_dbg)
  );

  sync_ram_clr #(.ADDR_SIZE(10), .WORD_SIZE(8), .MEMORY_SIZE(600)) u_dut2 (
    .clk(clk), .rst(rst), .cs(cs2), .wr(wr2), .addr(addr2), .data_in(data_in2),
    .clear(clear2), .data_out(data_out2), .valid(valid2), .busy(busy2),
    .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [0:1023];
  logic [7:0] last_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_ref();
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  endtask

  // One access on u_dut (must be idle); expected read data goes through exp_q.
  task automatic acc(input logic c, input logic w, input logic [9:0] a, input logic [7:0] d);
    logic       exp_v;
    logic [7:0] e;
    cs = c; wr = w; addr = a; data_in = d; clear = 1'b0;
    exp_v = c & ~w;
    if (exp_v) exp_q.push_back(ref_mem[a]);
    if (c && w) ref_mem[a] = d;
    tick();
    chk("valid", valid, exp_v);
    if (exp_v) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata", data_out, e);
        last_dout = e;
      end else begin
        chk("scoreboard_underflow", 1, 0);
      end
    end else begin
      chk("dout_hold", data_out, last_dout);
    end
    cs = 1'b0; wr = 1'b0;
  endtask

  // One access on u_dut2 with explicit expectations.
  task automatic acc2(input logic c, input logic w, input logic [9:0] a, input logic [7:0] d,
                      input logic ev, input logic [7:0] ed);
    cs2 = c; wr2 = w; addr2 = a; data_in2 = d; clear2 = 1'b0;
    tick();
    chk("valid2", valid2, ev);
    chk("dout2", data_out2, ed);
    cs2 = 1'b0; wr2 = 1'b0;
  endtask

  // Count the sample points at which each busy is high until both drop.
  task automatic count_busy(input int exp1, input int exp2);
    int c1 = 0;
    int c2 = 0;
    int n  = 0;
    while ((busy || busy2) && n < 5000) begin
      if (busy)  c1++;
      if (busy2) c2++;
      n++;
      tick();
    end
    chk("busy_cycles", c1, exp1);
    chk("busy2_cycles", c2, exp2);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       cs;
    logic       wr;
    logic [9:0] addr;
    logic [7:0] din;
    logic       exp_valid;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rc, rw;
    logic [9:0] ra;
    logic [7:0] rd;

    zero_ref();
    // Entry 0 follows the last back-to-back read (addr 50 -> 8'h64).
    vecs[0] = '{1'b1, 1'b1, 10'd7,    8'hA5, 1'b0, 8'h64};
    vecs[1] = '{1'b1, 1'b0, 10'd7,    8'h00, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 10'd7,    8'h00, 1'b0, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 10'd9,    8'h11, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 1'b0, 10'd9,    8'h00, 1'b1, 8'h12};
    vecs[5] = '{1'b1, 1'b1, 10'd1023, 8'h3C, 1'b0, 8'h12};
    vecs[6] = '{1'b1, 1'b0, 10'd1023, 8'h00, 1'b1, 8'h3C};
    vecs[7] = '{1'b1, 1'b0, 10'd0,    8'h00, 1'b1, 8'h00};

    // ---- reset state (asynchronous, before any clock edge) ----
    #1 rst = 1'b1;
    #2;
    chk("rst_dout", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_state", state_dbg, 1);
    chk("rst_busy2", busy2, 1);
    chk("rst_dout2", data_out2, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- post-reset sweep lengths ----
    count_busy(1024, 600);
    chk("idle_state", state_dbg, 0);

    // ---- reads of a freshly swept array ----
    acc(1'b1, 1'b0, 10'd0,    8'h00);
    acc(1'b1, 1'b0, 10'd511,  8'h00);
    acc(1'b1, 1'b0, 10'd1023, 8'h00);

    // ---- write ramp then back-to-back reads ----
    for (int k = 0; k <= 50; k++) acc(1'b1, 1'b1, 10'(k), 8'(k * 2));
    for (int k = 0; k <= 50; k++) acc(1'b1, 1'b0, 10'(k), 8'h00);

    // ---- table-driven vectors ----
    for (int i = 0; i < 8; i++) begin
      cs = vecs[i].cs; wr = vecs[i].wr; addr = vecs[i].addr; data_in = vecs[i].din;
      tick();
      chk("vec_valid", valid, vecs[i].exp_valid);
      chk("vec_dout", data_out, vecs[i].exp_dout);
      if (vecs[i].cs && vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].din;
      last_dout = vecs[i].exp_dout;
    end
    cs = 1'b0; wr = 1'b0;

    // ---- random reads/writes over a small window ----
    repeat (200) begin
      rc = ($urandom_range(0, 3) != 0);
      rw = 1'($urandom_range(0, 1));
      ra = 10'($urandom_range(0, 15));
      rd = 8'($urandom_range(0, 255));
      acc(rc, rw, ra, rd);
    end
    chk("queue_empty", exp_q.size(), 0);

    // ---- clear beats a same-cycle write ----
    acc(1'b1, 1'b1, 10'd3, 8'h33);
    acc(1'b1, 1'b0, 10'd3, 8'h00);
    cs = 1'b1; wr = 1'b1; addr = 10'd3; data_in = 8'h55; clear = 1'b1;
    tick();
    chk("clr_valid", valid, 0);
    chk("clr_dout_hold", data_out, last_dout);
    cs = 1'b0; wr = 1'b0; clear = 1'b0;
    count_busy(1024, 0);
    zero_ref();
    acc(1'b1, 1'b0, 10'd3, 8'h00);

    // ---- clear during clear restarts the sweep ----
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (99) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    count_busy(1024, 0);

    // ---- short array: out-of-range addresses and sweep length ----
    acc2(1'b1, 1'b1, 10'd599, 8'h99, 1'b0, 8'h00);
    acc2(1'b1, 1'b0, 10'd599, 8'h00, 1'b1, 8'h99);
    acc2(1'b1, 1'b1, 10'd700, 8'h77, 1'b0, 8'h99);
    acc2(1'b1, 1'b0, 10'd700, 8'h00, 1'b1, 8'h00);
    acc2(1'b1, 1'b1, 10'd600, 8'hEE, 1'b0, 8'h00);
    acc2(1'b1, 1'b0, 10'd600, 8'h00, 1'b1, 8'h00);
    acc2(1'b1, 1'b0, 10'd599, 8'h00, 1'b1, 8'h99);
    clear2 = 1'b1; tick(); clear2 = 1'b0;
    count_busy(0, 600);
    acc2(1'b1, 1'b0, 10'd599, 8'h00, 1'b1, 8'h00);

    // ---- accesses ignored during clear, then reset aborts the sweep ----
    acc(1'b1, 1'b1, 10'd5, 8'h5A);
    acc(1'b1, 1'b0, 10'd5, 8'h00);
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 299; i++) begin
      cs = 1'b1;
      wr = 1'($urandom_range(0, 1));
      addr = 10'($urandom_range(0, 15));
      data_in = 8'($urandom_range(1, 255));
      tick();
      chk("clr_ign_valid", valid, 0);
      chk("clr_ign_dout", data_out, 8'h5A);
      chk("clr_ign_busy", busy, 1);
    end
    cs = 1'b0; wr = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_busy2", busy2, 1);
    tick(); tick();
    chk("hold_rst_dout", data_out, 0);
    chk("hold_rst_valid", valid, 0);
    rst = 1'b0;
    count_busy(1024, 600);
    zero_ref();
    last_dout = '0;
    acc(1'b1, 1'b0, 10'd5, 8'h00);
    acc(1'b1, 1'b0, 10'd7, 8'h00);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_ram_clr.md
SYNC_RAM_CLR -- requirements
Module: sync_ram_clr

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 10, address width in bits.
REQ-002 SHALL have parameter WORD_SIZE, default 8, data word width in bits.
REQ-003 SHALL have parameter MEMORY_SIZE, default 1024, number of words; legal range 2 to 2**ADDR_SIZE.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cs  input  1  chip select; an access is taken only when high.
REQ-007 SHALL have port wr  input  1  1 = write, 0 = read, qualified by cs.
REQ-008 SHALL have port addr  input  ADDR_SIZE  word address.
REQ-009 SHALL have port data_in  input  WORD_SIZE  write data.
REQ-010 SHALL have port clear  input  1  single-cycle request to zero the whole array.
REQ-011 SHALL have port data_out  output  WORD_SIZE  registered read data.
REQ-012 SHALL have port valid  output  1  high for exactly one cycle when data_out carries a new read result.
REQ-013 SHALL have port busy  output  1  high while the clear engine runs; accesses are ignored.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-015 In CLEAR, SHALL write 0 to mem[ptr] each cycle and increment ptr from 0.
REQ-016 When ptr == MEMORY_SIZE-1, SHALL write that last word and enter IDLE at the same edge.
REQ-017 A full clear SHALL take exactly MEMORY_SIZE cycles; busy SHALL be low from the first cycle in IDLE.
REQ-018 SHALL ignore cs, wr, addr and data_in in CLEAR: no write, valid=0, data_out held.
REQ-019 In IDLE with cs=1, wr=1: SHALL write data_in to mem[addr] at the edge; valid=0 next cycle; data_out held.
REQ-020 In IDLE with cs=1, wr=0: SHALL load mem[addr] into data_out at the edge; valid=1 for that one following cycle (read latency 1).
REQ-021 In IDLE with cs=0: SHALL hold data_out and drive valid=0.
REQ-022 When addr >= MEMORY_SIZE: writes SHALL be dropped; reads SHALL return 0 with valid=1.
REQ-023 A read in the cycle immediately after a write to the same address SHALL return the newly written data.
REQ-024 clear=1 in IDLE SHALL enter CLEAR with ptr=0 at the next edge; busy=1 from that edge.
REQ-025 clear takes priority over an access in the same cycle; that access SHALL be dropped and valid=0.
REQ-026 clear=1 while in CLEAR SHALL restart ptr at 0, extending busy.
REQ-027 Back-to-back reads on consecutive cycles SHALL produce valid on consecutive cycles, each with its own addressed data.

Reset
REQ-028 While rst=1, asynchronously: data_out=0, valid=0, busy=1, state=CLEAR, ptr=0.
REQ-029 The array SHALL NOT be reset asynchronously; it is zeroed by the CLEAR sweep that starts at the first edge after rst falls.
REQ-030 rst asserted mid-operation (during CLEAR, a write or a read) SHALL abort it; the sweep SHALL restart from ptr=0 after release.

Verification
REQ-031 Release rst, defaults -> busy high for exactly 1024 cycles then low; read addr 0, 511 and 1023 -> data_out=0, valid=1.
REQ-032 Write k*2 mod 256 to addr k for k=0..50, then read addr 0..50 back-to-back -> data_out=2k on successive cycles, valid continuously high.
REQ-033 Write 8'hA5 to addr 7, read addr 7 on the next cycle -> data_out=8'hA5 one cycle later; cs=0 on the following cycle -> valid=0 and data_out stays 8'hA5.
REQ-034 Pulse clear with cs=1, wr=1, addr=3, data_in=8'h55 in the same cycle -> write dropped, busy=1 for 1024 cycles, then read addr 3 -> 0.
REQ-035 Assert rst at clear cycle 300, release, then count -> busy high for 1024 cycles after release; data_out=0 and valid=0 during rst.
REQ-036 Run with MEMORY_SIZE=600 and ADDR_SIZE=10: write to addr 700 -> no effect; read addr 700 -> data_out=0, valid=1; clear lasts exactly 600 cycles.
